// File: rtl/ysyx_25020037_axi_rd_slave_pkg.sv
// Shared definitions for the AXI read responder: response and burst codes
// plus the state encoding of the read-channel FSM.
package ysyx_25020037_axi_rd_slave_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
  localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/ysyx_25020037_axi_addr_gen.sv
// Beat address generator: holds the current beat address with the latched
// size/burst, steps it between beats and flags illegal or unmapped beats.
module ysyx_25020037_axi_addr_gen
  import ysyx_25020037_axi_rd_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          MEM_AW    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [31:0]       ld_addr,
  input  logic [2:0]        ld_size,
  input  logic [1:0]        ld_burst,
  input  logic              advance,
  output logic [MEM_AW-1:0] word_idx,
  output logic              slv_err,
  output logic              dec_err
);

  // Region size is computed one bit wider so a region spanning the whole
  // 32-bit space does not overflow.
  localparam logic [32:0] REGION_BYTES = 33'd4 << MEM_AW;

  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [31:0] next_addr;
  logic [31:0] offset;
  logic        in_range;

  // Latch the request on AR handshake, step the address between beats.
  // NOTE: these datapath registers are reset even though the FSM would mask
  // stale values; a mid-burst reset must leave no old address or burst type
  // behind to leak into error flags. Sequential state uses <= only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      size_q  <= '0;
      burst_q <= '0;
    end else if (load) begin
      addr_q  <= ld_addr;
      size_q  <= ld_size;
      burst_q <= ld_burst;
    end else if (advance) begin
      addr_q  <= next_addr;
    end
  end

  // INCR wraps modulo 2^32; FIXED and unsupported bursts hold the address
  // (unsupported bursts answer SLVERR on every beat anyway).
  assign next_addr = (burst_q == AXI_BURST_INCR) ? addr_q + (32'd1 << size_q) : addr_q;

  // Sub-word and unaligned addresses floor to the containing word.
  assign offset   = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, offset} < REGION_BYTES);
  assign word_idx = offset[MEM_AW+1:2];

  assign slv_err = (size_q > 3'd2) || burst_q[1];
  assign dec_err = !in_range;

endmodule

// File: rtl/ysyx_25020037_axi_rd_slave.sv
// AXI4 read-channel responder in front of a fixed-latency word memory.
// One transaction at a time; every beat costs ISSUE + MEM_LAT + RESP cycles.
module ysyx_25020037_axi_rd_slave
  import ysyx_25020037_axi_rd_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          MEM_AW    = 16,
  parameter int          MEM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arvalid,
  output logic              arready,
  input  logic [31:0]       araddr,
  input  logic [3:0]        arid,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  output logic              rvalid,
  input  logic              rready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic [3:0]        rid,
  output logic              mem_ren,
  output logic [MEM_AW-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata
);

  localparam int             LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

  rd_state_e         state_q, state_d;
  logic [7:0]        len_q;
  logic [7:0]        beat_cnt_q;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic              ar_hs, r_hs;
  logic              advance;
  logic              slv_err, dec_err;
  logic [1:0]        beat_resp;
  logic              beat_ok;
  logic              beat_last;

  assign ar_hs     = arvalid & arready;
  assign r_hs      = rvalid & rready;
  assign beat_last = (beat_cnt_q == len_q);
  assign beat_resp = slv_err ? AXI_RESP_SLVERR :
                     dec_err ? AXI_RESP_DECERR : AXI_RESP_OKAY;
  assign beat_ok   = (beat_resp == AXI_RESP_OKAY);

  ysyx_25020037_axi_addr_gen #(
    .BASE_ADDR (BASE_ADDR),
    .MEM_AW    (MEM_AW)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ar_hs),
    .ld_addr  (araddr),
    .ld_size  (arsize),
    .ld_burst (arburst),
    .advance  (advance),
    .word_idx (mem_raddr),
    .slv_err  (slv_err),
    .dec_err  (dec_err)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic plus the memory strobe and address-advance pulse.
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    mem_ren = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (ar_hs) state_d = ST_ISSUE;
      ST_ISSUE: begin
        mem_ren = beat_ok;
        state_d = ST_WAIT;
      end
      ST_WAIT:  if (lat_cnt_q == '0) state_d = ST_RESP;
      ST_RESP: begin
        if (r_hs) begin
          if (rlast) begin
            state_d = ST_IDLE;
          end else begin
            advance = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // AR side: registered arready follows the next state, request fields latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arready <= 1'b0;
      rid     <= '0;
      len_q   <= '0;
    end else begin
      arready <= (state_d == ST_IDLE);
      if (ar_hs) begin
        rid   <= arid;
        len_q <= arlen;
      end
    end
  end

  // Beat and latency counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      lat_cnt_q  <= '0;
    end else begin
      if (ar_hs) beat_cnt_q <= '0;
      else if (advance) beat_cnt_q <= beat_cnt_q + 8'd1;

      if (state_q == ST_ISSUE) lat_cnt_q <= LAT_INIT;
      else if (state_q == ST_WAIT && lat_cnt_q != '0) lat_cnt_q <= lat_cnt_q - LAT_W'(1);
    end
  end

  // R channel registers: loaded when the memory word is due, held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= AXI_RESP_OKAY;
      rlast  <= 1'b0;
    end else if (state_q == ST_WAIT && lat_cnt_q == '0) begin
      rvalid <= 1'b1;
      rdata  <= beat_ok ? mem_rdata : 32'd0;
      rresp  <= beat_resp;
      rlast  <= beat_last;
    end else if (state_q == ST_RESP && r_hs) begin
      rvalid <= 1'b0;
      rlast  <= 1'b0;
    end
  end

endmodule
